// File: rtl/brick_field_engine.sv
// brick_field_engine: ROWS x COLS brick wall renderer with a once-per-frame ball/brick
// collision scan that clears at most one brick per frame and reports the hit.
module brick_field_engine #(
   parameter int          ROWS       = 4,
   parameter int          COLS       = 8,
   parameter int          BRICK_W_LG = 6,
   parameter int          BRICK_H_LG = 4,
   parameter int          TOP        = 32,
   parameter int          GAP        = 2,
   parameter int          BALL_SIZE  = 8,
   parameter logic [11:0] BRICK_RGB  = 12'hF80,
   parameter logic [11:0] BALL_RGB   = 12'hFFF,
   parameter logic [11:0] BG_RGB     = 12'h000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pTick,
   input  logic       videoON,
   input  logic [9:0] pixelX,
   input  logic [9:0] pixelY,
   input  logic       frameTick,
   input  logic [9:0] ballX,
   input  logic [9:0] ballY,
   input  logic       restart,
   output logic [3:0] objRed,
   output logic [3:0] objGreen,
   output logic [3:0] objBlue,
   output logic       hitValid,
   output logic [2:0] hitRow,
   output logic [3:0] hitCol,
   output logic       hitSide,
   output logic [7:0] bricksLeft,
   output logic       levelClear
);
   localparam int N = ROWS * COLS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] FULL = '1;
   localparam logic [7:0] N8 = 8'(N);
   localparam logic [BRICK_W_LG-1:0] X_GAP = BRICK_W_LG'((1 << BRICK_W_LG) - GAP);
   localparam logic [BRICK_H_LG-1:0] Y_GAP = BRICK_H_LG'((1 << BRICK_H_LG) - GAP);
   localparam logic [11:0] BW = 12'((1 << BRICK_W_LG) - GAP);
   localparam logic [11:0] BH = 12'((1 << BRICK_H_LG) - GAP);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nx;

   logic [N-1:0] alive;
   logic [9:0] dy, prow, pcol;
   logic [10:0] px_end, py_end;
   logic s1_brick, s1_ball, s1_video;
   logic [IW-1:0] s1_idx;
   logic [11:0] rgb;

   assign dy = pixelY - 10'(TOP);
   assign prow = dy >> BRICK_H_LG;
   assign pcol = pixelX >> BRICK_W_LG;
   assign px_end = {1'b0, ballX} + 11'(BALL_SIZE);
   assign py_end = {1'b0, ballY} + 11'(BALL_SIZE);
   assign {objRed, objGreen, objBlue} = rgb;

   // Two-stage render pipe, advancing only on pixel ticks
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         s1_brick <= 1'b0;
         s1_ball  <= 1'b0;
         s1_video <= 1'b0;
         s1_idx   <= '0;
         rgb      <= '0;
      end else if (pTick) begin
         s1_brick <= pixelY >= 10'(TOP) && prow < 10'(ROWS) && pcol < 10'(COLS)
                     && pixelX[BRICK_W_LG-1:0] < X_GAP && dy[BRICK_H_LG-1:0] < Y_GAP;
         s1_ball  <= pixelX >= ballX && {1'b0, pixelX} < px_end
                     && pixelY >= ballY && {1'b0, pixelY} < py_end;
         s1_video <= videoON;
         s1_idx   <= IW'(prow * 10'(COLS) + pcol);
         rgb      <= !s1_video ? 12'h000 : s1_ball ? BALL_RGB
                     : (s1_brick && alive[s1_idx]) ? BRICK_RGB : BG_RGB;
      end

   logic [2:0] scan_row;
   logic [3:0] scan_col;
   logic [IW-1:0] scan_idx;
   logic [11:0] x0, x1, y0, y1, bx0, bx1, by0, by1, ox, oy;
   logic overlap, hit, last;

   assign x0 = 12'(scan_col) << BRICK_W_LG;
   assign y0 = 12'(TOP) + (12'(scan_row) << BRICK_H_LG);
   assign x1 = x0 + BW;
   assign y1 = y0 + BH;
   assign bx0 = {2'b00, ballX};
   assign by0 = {2'b00, ballY};
   assign bx1 = bx0 + 12'(BALL_SIZE);
   assign by1 = by0 + 12'(BALL_SIZE);
   assign overlap = bx0 < x1 && x0 < bx1 && by0 < y1 && y0 < by1;
   assign ox = (bx1 < x1 ? bx1 : x1) - (bx0 > x0 ? bx0 : x0);
   assign oy = (by1 < y1 ? by1 : y1) - (by0 > y0 ? by0 : y0);
   assign last = scan_idx == IW'(N - 1);

   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= restart ? IDLE : state_nx;

   always_comb begin
      hit = state == SCAN && alive[scan_idx] && overlap;
      state_nx = (state == IDLE && frameTick) ? SCAN
               : (state == SCAN && (hit || last)) ? DONE
               : (state == DONE) ? IDLE : state;
   end

   // Restart wins over a hit landing in the same clock
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         alive      <= FULL;
         bricksLeft <= N8;
         hitValid   <= 1'b0;
         hitRow     <= '0;
         hitCol     <= '0;
         hitSide    <= 1'b0;
         levelClear <= 1'b0;
         scan_row   <= '0;
         scan_col   <= '0;
         scan_idx   <= '0;
      end else begin
         levelClear <= bricksLeft == '0;
         hitValid   <= hit && !restart;
         if (restart) begin
            alive      <= FULL;
            bricksLeft <= N8;
         end else if (hit) begin
            alive[scan_idx] <= 1'b0;
            bricksLeft      <= bricksLeft - 8'd1;
            hitRow          <= scan_row;
            hitCol          <= scan_col;
            hitSide         <= ox < oy;
         end
         if (state != SCAN) begin
            scan_row <= '0;
            scan_col <= '0;
            scan_idx <= '0;
         end else begin
            scan_idx <= scan_idx + 1'b1;
            scan_col <= (scan_col == 4'(COLS - 1)) ? 4'd0 : scan_col + 4'd1;
            scan_row <= (scan_col == 4'(COLS - 1)) ? scan_row + 3'd1 : scan_row;
         end
      end
endmodule

// File: tb/tb_brick_field_engine.sv
// tb_brick_field_engine: randomized render and collision checks against a behavioural
// model of the 4x8 wall (62x14 bricks at 64x16 pitch, 8 px ball).
module tb_brick_field_engine;
   logic clock = 0, reset = 0, pTick = 0, videoON = 0, frameTick = 0, restart = 0;
   logic [9:0] pixelX = 0, pixelY = 0, ballX = 0, ballY = 0;
   logic [3:0] objRed, objGreen, objBlue;
   logic hitValid, hitSide, levelClear;
   logic [2:0] hitRow;
   logic [3:0] hitCol;
   logic [7:0] bricksLeft;
   int tests = 0, fails = 0;
   bit model_alive [32];
   int model_left;

   brick_field_engine dut (
      .clock(clock), .reset(reset), .pTick(pTick), .videoON(videoON),
      .pixelX(pixelX), .pixelY(pixelY), .frameTick(frameTick),
      .ballX(ballX), .ballY(ballY), .restart(restart),
      .objRed(objRed), .objGreen(objGreen), .objBlue(objBlue),
      .hitValid(hitValid), .hitRow(hitRow), .hitCol(hitCol), .hitSide(hitSide),
      .bricksLeft(bricksLeft), .levelClear(levelClear)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic void model_full();
      for (int i = 0; i < 32; i++) model_alive[i] = 1;
      model_left = 32;
   endfunction

   function automatic logic [11:0] ref_rgb(int x, int y, bit v, int bx, int by);
      int r, c;
      if (!v) return 12'h000;
      if (x >= bx && x < bx + 8 && y >= by && y < by + 8) return 12'hFFF;
      if (y < 32) return 12'h000;
      r = (y - 32) / 16;
      c = x / 64;
      if (r < 4 && c < 8 && x % 64 < 62 && (y - 32) % 16 < 14 && model_alive[r * 8 + c])
         return 12'hF80;
      return 12'h000;
   endfunction

   function automatic int find_hit(int bx, int by, output bit side);
      int x0, y0, ox, oy;
      side = 0;
      for (int i = 0; i < 32; i++) begin
         x0 = (i % 8) * 64;
         y0 = 32 + (i / 8) * 16;
         if (model_alive[i] && bx < x0 + 62 && x0 < bx + 8 && by < y0 + 14 && y0 < by + 8) begin
            ox = ((bx + 8 < x0 + 62) ? bx + 8 : x0 + 62) - ((bx > x0) ? bx : x0);
            oy = ((by + 8 < y0 + 14) ? by + 8 : y0 + 14) - ((by > y0) ? by : y0);
            side = ox < oy;
            return i;
         end
      end
      return -1;
   endfunction

   task automatic render_run(input int n);
      logic [11:0] q[$];
      int x, y;
      bit v;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0: begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
            1: begin x = $urandom_range(0, 520); y = $urandom_range(24, 104); end
            default: begin
               x = int'(ballX) + int'($urandom_range(0, 13)) - 3;
               y = int'(ballY) + int'($urandom_range(0, 13)) - 3;
            end
         endcase
         if (x < 0) x = 0;
         if (y < 0) y = 0;
         v = x < 640 && y < 480 && $urandom_range(0, 7) != 0;
         pixelX = 10'(x); pixelY = 10'(y); videoON = v; pTick = 1;
         q.push_back(ref_rgb(int'(pixelX), int'(pixelY), v, int'(ballX), int'(ballY)));
         @(posedge clock); #1;
         pTick = 0;
         if (q.size() > 2) void'(q.pop_front());
         if (q.size() == 2) begin
            tests++;
            if ({objRed, objGreen, objBlue} !== q[0]) begin
               fails++;
               $display("FAIL render pixel: got %h expected %h", {objRed, objGreen, objBlue}, q[0]);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            pixelX = 10'($urandom_range(0, 1023)); pixelY = 10'($urandom_range(0, 1023));
            videoON = 1;
            @(posedge clock); #1;
            if (q.size() == 2) begin
               tests++;
               if ({objRed, objGreen, objBlue} !== q[0]) begin
                  fails++;
                  $display("FAIL render_hold: got %h expected %h", {objRed, objGreen, objBlue}, q[0]);
               end
            end
         end
      end
   endtask

   task automatic do_frame(input int bx, input int by, input int extra);
      int exp_idx, pulses, lat, lc_hit, lc_next;
      bit exp_side;
      logic [2:0] g_row;
      logic [3:0] g_col;
      logic g_side;
      exp_idx = find_hit(bx, by, exp_side);
      ballX = 10'(bx); ballY = 10'(by);
      frameTick = 1;
      @(posedge clock); #1;
      frameTick = 0;
      pulses = 0; lat = -1; lc_hit = -1; lc_next = -1;
      g_row = 0; g_col = 0; g_side = 0;
      for (int i = 0; i <= 40; i++) begin
         if (lat >= 0 && i == lat + 1) lc_next = int'(levelClear);
         if (hitValid) begin
            pulses++;
            if (lat < 0) begin
               lat = i; lc_hit = int'(levelClear);
               g_row = hitRow; g_col = hitCol; g_side = hitSide;
            end
         end
         frameTick = (i == extra);
         @(posedge clock); #1;
      end
      frameTick = 0;
      tests++;
      if (pulses != (exp_idx >= 0 ? 1 : 0)) begin
         fails++;
         $display("FAIL hit_pulses ball(%0d,%0d): got %0d expected %0d", bx, by, pulses, exp_idx >= 0 ? 1 : 0);
      end
      if (exp_idx >= 0) begin
         model_alive[exp_idx] = 0;
         model_left--;
         tests++;
         if (g_row !== 3'(exp_idx / 8) || g_col !== 4'(exp_idx % 8)) begin
            fails++;
            $display("FAIL hit_rowcol: got r%0d c%0d expected r%0d c%0d", g_row, g_col, exp_idx / 8, exp_idx % 8);
         end
         tests++;
         if (g_side !== exp_side) begin
            fails++;
            $display("FAIL hit_side idx %0d: got %0d expected %0d", exp_idx, g_side, exp_side);
         end
         tests++;
         if (lat != exp_idx + 1) begin
            fails++;
            $display("FAIL scan_latency idx %0d: got %0d expected %0d", exp_idx, lat, exp_idx + 1);
         end
         tests++;
         if (lc_hit != 0 || lc_next != (model_left == 0 ? 1 : 0)) begin
            fails++;
            $display("FAIL level_clear_timing: got %0d,%0d expected 0,%0d", lc_hit, lc_next, model_left == 0);
         end
      end
      tests++;
      if (bricksLeft !== 8'(model_left)) begin
         fails++;
         $display("FAIL bricks_left: got %0d expected %0d", bricksLeft, model_left);
      end
   endtask

   task automatic do_restart();
      restart = 1;
      @(posedge clock); #1;
      restart = 0;
      model_full();
      tests++;
      if (bricksLeft !== 8'd32 || hitValid !== 1'b0) begin
         fails++;
         $display("FAIL restart_left: got %0d/%0b expected 32/0", bricksLeft, hitValid);
      end
      @(posedge clock); #1;
      tests++;
      if (levelClear !== 1'b0) begin
         fails++;
         $display("FAIL restart_level_clear: got %0b expected 0", levelClear);
      end
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) @(posedge clock);
      #1;
      model_full();
      tests++;
      if ({objRed, objGreen, objBlue} !== 12'h000 || hitValid !== 1'b0 || levelClear !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got rgb %h hv %b lc %b expected 000 0 0",
                  {objRed, objGreen, objBlue}, hitValid, levelClear);
      end
      tests++;
      if (hitRow !== 3'd0 || hitCol !== 4'd0 || hitSide !== 1'b0 || bricksLeft !== 8'd32) begin
         fails++;
         $display("FAIL reset_hit_regs: got r%0d c%0d s%0d left %0d expected 0 0 0 32",
                  hitRow, hitCol, hitSide, bricksLeft);
      end
      reset = 1;
      @(posedge clock); #1;
   endtask

   task automatic test_sweep();
      ballX = 10'd700; ballY = 10'd500;
      render_run(1200);
      ballX = 10'd100; ballY = 10'd40;
      render_run(500);
   endtask

   task automatic test_straddle();
      do_frame(58, 36, -1);
      ballX = 10'd700; ballY = 10'd500;
      render_run(300);
   endtask

   task automatic test_single_hit();
      do_frame(70, 40, -1);
      ballX = 10'd700; ballY = 10'd500;
      render_run(300);
   endtask

   task automatic test_clear_all();
      for (int i = 0; i < 32; i++)
         if (model_alive[i]) do_frame((i % 8) * 64 + 20, 32 + (i / 8) * 16 + 3, -1);
      do_frame(100, 40, -1);
      tests++;
      if (levelClear !== 1'b1) begin
         fails++;
         $display("FAIL level_clear_held: got %0b expected 1", levelClear);
      end
      ballX = 10'd700; ballY = 10'd500;
      render_run(200);
      do_restart();
      render_run(200);
   endtask

   task automatic test_restart_same_clock();
      int pulses;
      ballX = 10'd212; ballY = 10'd35;
      frameTick = 1;
      @(posedge clock); #1;
      frameTick = 0;
      pulses = 0;
      for (int i = 1; i <= 44; i++) begin
         restart = (i == 4);
         @(posedge clock); #1;
         if (hitValid) pulses++;
      end
      restart = 0;
      tests++;
      if (pulses != 0 || bricksLeft !== 8'd32) begin
         fails++;
         $display("FAIL restart_vs_hit: got pulses %0d left %0d expected 0 32", pulses, bricksLeft);
      end
      do_frame(212, 35, -1);
   endtask

   task automatic test_frame_during_scan();
      do_frame(4 * 64 + 20, 32 + 2 * 16 + 3, 5);
      do_frame(58, 52, 9);
   endtask

   task automatic test_async_reset();
      int pulses;
      ballX = 10'(6 * 64 + 20); ballY = 10'(32 + 3 * 16 + 3);
      frameTick = 1;
      @(posedge clock); #1;
      frameTick = 0;
      repeat (8) @(posedge clock);
      #3 reset = 0;
      #1;
      model_full();
      tests++;
      if (bricksLeft !== 8'd32 || hitValid !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: got left %0d hv %b expected 32 0", bricksLeft, hitValid);
      end
      @(posedge clock); #1;
      reset = 1;
      pulses = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (hitValid) pulses++;
      end
      tests++;
      if (pulses != 0 || bricksLeft !== 8'd32 || levelClear !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: got pulses %0d left %0d lc %b expected 0 32 0",
                  pulses, bricksLeft, levelClear);
      end
      do_frame(6 * 64 + 20, 32 + 3 * 16 + 3, -1);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_straddle();
      test_single_hit();
      test_clear_all();
      test_restart_same_clock();
      test_frame_during_scan();
      do_frame(20, 35, -1);
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
